hash_mem_arbiter: RTL and testbench

HASH_MEM_ARBITER -- requirements
Module: hash_mem_arbiter

---
 rtl/hash_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_hash_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_mem_arbiter.sv
// rtl/hash_mem_arbiter.sv - round-robin arbiter sharing one memory port among N_REQ hash cores
// Optional grant hold limit enabled by defining HASH_ARB_TIMEOUT_EN.
module hash_mem_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      m_we,
  input  logic [16*N_REQ-1:0]   m_addr,
  input  logic [32*N_REQ-1:0]   m_wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rvalid,
  output logic [31:0]           rdata,
  output logic                  timeout,
  output logic                  mem_clk,
  output logic                  mem_we,
  output logic [15:0]           mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_param_check
    $error("hash_mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [15:0]       addr_q, addr_d;

  logic [15:0]       addr_arr  [N_REQ];
  logic [31:0]       wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr[16*g +: 16];
    assign wdata_arr[g] = m_wdata[32*g +: 32];
  end

  logic        own_req;
  logic        own_we;
  logic [15:0] own_addr;
  logic [31:0] own_wdata;

  assign own_req   = req[owner_q];
  assign own_we    = m_we[owner_q];
  assign own_addr  = addr_arr[owner_q];
  assign own_wdata = wdata_arr[owner_q];

  // Search starts just after ptr, so the previous owner is always considered last.
  logic          win_found;
  logic [IW-1:0] win_idx;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!win_found && req[IW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  logic hold_expired;
  logic preempt;

  assign preempt = (state_q == GRANT) && own_req && hold_expired;

`ifdef HASH_ARB_TIMEOUT_EN
  logic [15:0] hold_q, hold_d;
  logic        timeout_q;

  assign hold_d       = (state_q == GRANT) ? hold_q + 16'd1 : 16'd0;
  assign hold_expired = (hold_q == 16'(MAX_HOLD - 1));
  assign timeout      = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= preempt;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    rvalid_d = '0;
    addr_d   = addr_q;
    case (state_q)
      IDLE, HANDOVER: begin
        gnt_d   = '0;
        state_d = IDLE;
        if (win_found) begin
          state_d          = GRANT;
          owner_d          = win_idx;
          gnt_d[win_idx]   = 1'b1;
        end
      end
      GRANT: begin
        addr_d = own_addr;
        if (!own_we) rvalid_d = gnt_q;
        if (!own_req || preempt) begin
          state_d = HANDOVER;
          ptr_d   = owner_q;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= IW'(N_REQ - 1);
      gnt_q    <= '0;
      rvalid_q <= '0;
      addr_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      addr_q   <= addr_d;
    end
  end

  // Memory side mirrors the owner combinationally; address holds between grants.
  assign mem_we         = (state_q == GRANT) && own_we;
  assign mem_addr       = (state_q == GRANT) ? own_addr : addr_q;
  assign mem_write_data = (state_q == GRANT) ? own_wdata : 32'd0;
  assign mem_clk        = clk;
  assign rdata          = mem_read_data;
  assign gnt            = gnt_q;
  assign rvalid         = rvalid_q;

endmodule

// File: tb/tb_hash_mem_arbiter.sv
// tb/tb_hash_mem_arbiter.sv - directed table and sequence bench for hash_mem_arbiter
module tb_hash_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, m_we;
  logic [63:0]  m_addr;
  logic [127:0] m_wdata;
  logic [3:0]   gnt, rvalid;
  logic [31:0]  rdata;
  logic         timeout, mem_clk, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data, mem_read_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hash_mem_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .timeout(timeout), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [15:0] a1;
    logic [3:0]  e_gnt;
    logic        e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_rv;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [15:0] a1,
                              input logic [3:0] eg, input logic ew, input logic [15:0] ea,
                              input logic [31:0] ed, input logic [3:0] erv);
    vec_t v;
    v.req = r; v.we = w; v.a1 = a1; v.e_gnt = eg; v.e_we = ew;
    v.e_addr = ea; v.e_wdata = ed; v.e_rv = erv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5];
    int cnt;
    logic [31:0] e;

    // core addresses {3,2,1,0}; core 1 address is replaced per vector
    m_addr        = {16'h0333, 16'h0040, 16'h0111, 16'h0100};
    m_wdata       = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h0C0C0C0C};
    mem_read_data = 32'h0;
    reset = 1'b1;
    req   = 4'b1010;
    m_we  = 4'b0000;

    tbl[0]  = mk(4'b1010, 4'b0000, 16'h0111, 4'b0000, 1'b0, 16'h0000, 32'h00000000, 4'b0000);
    tbl[1]  = mk(4'b1010, 4'b0000, 16'h0111, 4'b0010, 1'b0, 16'h0111, 32'h11111111, 4'b0000);
    tbl[2]  = mk(4'b1010, 4'b0010, 16'h0112, 4'b0010, 1'b1, 16'h0112, 32'h11111111, 4'b0010);
    tbl[3]  = mk(4'b1010, 4'b0000, 16'h0113, 4'b0010, 1'b0, 16'h0113, 32'h11111111, 4'b0000);
    tbl[4]  = mk(4'b1000, 4'b0000, 16'h0114, 4'b0010, 1'b0, 16'h0114, 32'h11111111, 4'b0010);
    tbl[5]  = mk(4'b1000, 4'b1000, 16'h0115, 4'b0000, 1'b0, 16'h0114, 32'h00000000, 4'b0010);
    tbl[6]  = mk(4'b1000, 4'b1000, 16'h0115, 4'b1000, 1'b1, 16'h0333, 32'h33333333, 4'b0000);
    tbl[7]  = mk(4'b1000, 4'b0000, 16'h0115, 4'b1000, 1'b0, 16'h0333, 32'h33333333, 4'b0000);
    tbl[8]  = mk(4'b0000, 4'b0000, 16'h0115, 4'b1000, 1'b0, 16'h0333, 32'h33333333, 4'b1000);
    tbl[9]  = mk(4'b0000, 4'b0000, 16'h0115, 4'b0000, 1'b0, 16'h0333, 32'h00000000, 4'b1000);
    tbl[10] = mk(4'b0100, 4'b0100, 16'h0115, 4'b0000, 1'b0, 16'h0333, 32'h00000000, 4'b0000);
    tbl[11] = mk(4'b0100, 4'b0100, 16'h0115, 4'b0100, 1'b1, 16'h0040, 32'hDEADBEEF, 4'b0000);
    tbl[12] = mk(4'b0000, 4'b0000, 16'h0115, 4'b0100, 1'b0, 16'h0040, 32'hDEADBEEF, 4'b0000);
    tbl[13] = mk(4'b0000, 4'b0000, 16'h0115, 4'b0000, 1'b0, 16'h0040, 32'h00000000, 4'b0100);
    tbl[14] = mk(4'b0000, 4'b0000, 16'h0115, 4'b0000, 1'b0, 16'h0040, 32'h00000000, 4'b0000);

    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_timeout", timeout, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      req            = tbl[i].req;
      m_we           = tbl[i].we;
      m_addr[31:16]  = tbl[i].a1;
      mem_read_data  = 32'hA5A50000 | 32'(i);
      #1;
      chk($sformatf("v%0d_gnt", i), gnt, tbl[i].e_gnt);
      chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_write_data, tbl[i].e_wdata);
      chk($sformatf("v%0d_rvalid", i), rvalid, tbl[i].e_rv);
      chk($sformatf("v%0d_rdata", i), rdata, 32'hA5A50000 | 32'(i));
      chk($sformatf("v%0d_timeout", i), timeout, 0);
      tick;
    end

    // full contention round robin, each owner keeps req for 3 cycles then drops it once
    reset = 1'b1;
    req   = 4'b1111;
    m_we  = 4'b1111;
    @(posedge clk);
    #1 reset = 1'b0;
    tick;
    order = '{0, 1, 2, 3, 0};
    for (int s = 0; s < 5; s++) begin
      e = 32'd1 << order[s];
      chk($sformatf("rr%0d_gnt", s), gnt, e);
      chk($sformatf("rr%0d_mem_we", s), mem_we, 1);
      tick;
      tick;
      tick;
      req[order[s]] = 1'b0;
      tick;
      chk($sformatf("rr%0d_ho_gnt", s), gnt, 0);
      chk($sformatf("rr%0d_ho_mem_we", s), mem_we, 0);
      if (s < 4) req[order[s]] = 1'b1;
      else req = 4'b0000;
      tick;
    end

    // reset in the middle of a core 1 write burst
    req  = 4'b0010;
    m_we = 4'b0010;
    m_addr[31:16] = 16'h0222;
    tick;
    chk("mid_gnt", gnt, 4'b0010);
    chk("mid_mem_we", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    req = 4'b0011;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("post_rst_gnt", gnt, 0);
    tick;
    chk("post_rst_first", gnt, 4'b0001);
    req  = 4'b0000;
    m_we = 4'b0000;
    tick;
    tick;

    // core 0 never lets go while core 3 waits
    reset = 1'b1;
    req   = 4'b1001;
    @(posedge clk);
    #1 reset = 1'b0;
    tick;
`ifdef HASH_ARB_TIMEOUT_EN
    cnt = 0;
    while (gnt == 4'b0001 && cnt < 50) begin
      chk("hold_no_timeout", timeout, 0);
      cnt++;
      tick;
    end
    chk("hold_cycles", cnt, 8);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_ho_gnt", gnt, 0);
    tick;
    chk("timeout_clear", timeout, 0);
    chk("preempt_winner", gnt, 4'b1000);
`else
    cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      if (gnt == 4'b0001 && timeout == 1'b0) cnt++;
      tick;
    end
    chk("hold_1000", cnt, 1000);
    chk("hold_still_gnt", gnt, 4'b0001);
`endif
    req = 4'b0000;
    tick;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
